// File: rtl/pipe_pkg.sv
//==============================================================================
// Module      : pipe_pkg
// Description : Shared tag type and forward-select encodings for the hazard unit.
// Revision    : 1.0
//==============================================================================
`default_nettype none

package pipe_pkg;

    localparam int PIPE_REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic                   valid;
        logic [PIPE_REG_AW-1:0] rd;
        logic                   reg_write;
        logic                   mem_read;
        logic [PIPE_REG_AW-1:0] rs1;
        logic [PIPE_REG_AW-1:0] rs2;
        logic                   rs1_used;
        logic                   rs2_used;
    } hazard_tag_t;

    localparam hazard_tag_t BUBBLE_TAG = '0;

    // x0 is hard-wired, so a tag targeting it never produces a usable result.
    function automatic logic tag_writes(input hazard_tag_t t);
        return t.valid && t.reg_write && (t.rd != '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_tag_reg.sv
//==============================================================================
// Module      : hazard_tag_reg
// Description : One pipeline stage of hazard tags with hold and bubble insertion.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module hazard_tag_reg
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        load_bubble,
    input  hazard_tag_t d,
    output hazard_tag_t q
);

    hazard_tag_t tag_d;
    hazard_tag_t tag_q;

    // Hold wins over bubble so a frozen pipeline keeps its instruction.
    always_comb begin
        tag_d = tag_q;
        if (!hold) begin
            tag_d = load_bubble ? BUBBLE_TAG : d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= BUBBLE_TAG;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign q = tag_q;

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
//==============================================================================
// Module      : pipe_hazard_ctrl
// Description : Forwarding selects, load-use stall and branch flush control.
//               Optional perf counters enabled by HAZARD_PERF_CNT_EN.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    input  logic              ext_stall,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    hazard_tag_t id_tag;
    hazard_tag_t tag_ex;
    hazard_tag_t tag_mem;
    hazard_tag_t tag_wb;
    logic        load_use;
    logic        hold_all;
    logic        bubble_ex;

    function automatic logic [1:0] fwd_sel(input hazard_tag_t ex, input hazard_tag_t mem,
                                           input hazard_tag_t wb,
                                           input logic [PIPE_REG_AW-1:0] src,
                                           input logic used);
        if (!ex.valid || !used) return FWD_RF;
        if (tag_writes(mem) && mem.rd == src) return FWD_MEM;
        if (tag_writes(wb) && wb.rd == src) return FWD_WB;
        return FWD_RF;
    endfunction

    always_comb begin
        id_tag           = BUBBLE_TAG;
        id_tag.valid     = id_valid;
        id_tag.rd        = id_rd;
        id_tag.reg_write = id_reg_write;
        id_tag.mem_read  = id_mem_read;
        id_tag.rs1       = id_rs1;
        id_tag.rs2       = id_rs2;
        id_tag.rs1_used  = id_rs1_used;
        id_tag.rs2_used  = id_rs2_used;
    end

    assign load_use = id_valid && tag_ex.valid && tag_ex.mem_read && (tag_ex.rd != '0) &&
                      ((id_rs1_used && id_rs1 == tag_ex.rd) ||
                       (id_rs2_used && id_rs2 == tag_ex.rd));

    // Priority: reset, then ext_stall, then branch, then load-use.
    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        hold_all   = 1'b0;
        bubble_ex  = 1'b0;
        if (rst_n) begin
            if (ext_stall) begin
                pc_we    = 1'b0;
                ifid_we  = 1'b0;
                hold_all = 1'b1;
            end else if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                bubble_ex  = 1'b1;
            end else if (load_use) begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                idex_flush = 1'b1;
                bubble_ex  = 1'b1;
            end
        end
    end

    assign fwd_a = fwd_sel(tag_ex, tag_mem, tag_wb, tag_ex.rs1, tag_ex.rs1_used);
    assign fwd_b = fwd_sel(tag_ex, tag_mem, tag_wb, tag_ex.rs2, tag_ex.rs2_used);

    hazard_tag_reg u_tag_ex (
        .clk         (clk),
        .rst_n       (rst_n),
        .hold        (hold_all),
        .load_bubble (bubble_ex),
        .d           (id_tag),
        .q           (tag_ex)
    );

    hazard_tag_reg u_tag_mem (
        .clk         (clk),
        .rst_n       (rst_n),
        .hold        (hold_all),
        .load_bubble (1'b0),
        .d           (tag_ex),
        .q           (tag_mem)
    );

    hazard_tag_reg u_tag_wb (
        .clk         (clk),
        .rst_n       (rst_n),
        .hold        (hold_all),
        .load_bubble (1'b0),
        .d           (tag_mem),
        .q           (tag_wb)
    );

    // WB only ever supplies a result; its source fields are dead.
    logic unused_tag_bits;
    assign unused_tag_bits = ^{tag_wb.mem_read, tag_wb.rs1, tag_wb.rs2,
                               tag_wb.rs1_used, tag_wb.rs2_used};

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!ext_stall) begin
            if (ex_branch_taken) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end else if (load_use) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
//==============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl (honours HAZARD_PERF_CNT_EN).
// Revision    : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pipe_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              ex_branch_taken;
    logic              ext_stall;
    logic              pc_we;
    logic              ifid_we;
    logic              ifid_flush;
    logic              idex_flush;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .ext_stall       (ext_stall),
        .pc_we           (pc_we),
        .ifid_we         (ifid_we),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    // Reference model: the instructions currently in EX, MEM, WB (index 0..2).
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
    } instr_t;

    instr_t pipe[3];
    int     exp_stalls;
    int     exp_flushes;
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit produces(input instr_t t);
        return t.v && t.rw && t.rd != 0;
    endfunction

    function automatic logic [1:0] model_fwd(input int src, input bit used);
        if (!pipe[0].v || !used) return 2'd0;
        for (int s = 1; s <= 2; s++) begin
            if (produces(pipe[s]) && pipe[s].rd == src) return (s == 1) ? 2'd2 : 2'd1;
        end
        return 2'd0;
    endfunction

    function automatic bit model_load_use();
        if (!id_valid || !pipe[0].v || !pipe[0].mr || pipe[0].rd == 0) return 1'b0;
        return (id_rs1_used && int'(id_rs1) == pipe[0].rd) ||
               (id_rs2_used && int'(id_rs2) == pipe[0].rd);
    endfunction

    task automatic reset_model();
        for (int s = 0; s < 3; s++) pipe[s] = '{default: 0};
        exp_stalls  = 0;
        exp_flushes = 0;
    endtask

    task automatic set_id(input bit v, input int rd, input bit rw, input bit mr,
                          input int rs1, input bit u1, input int rs2, input bit u2);
        id_valid     = v;
        id_rd        = REG_AW'(rd);
        id_reg_write = rw;
        id_mem_read  = mr;
        id_rs1       = REG_AW'(rs1);
        id_rs1_used  = u1;
        id_rs2       = REG_AW'(rs2);
        id_rs2_used  = u2;
    endtask

    task automatic nop();
        set_id(1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    // Compare every output with the model, away from the rising edge.
    task automatic settle();
        bit e_pc, e_ifid_we, e_ifid_fl, e_idex_fl;
        @(negedge clk);
        e_pc = 1; e_ifid_we = 1; e_ifid_fl = 0; e_idex_fl = 0;
        if (rst_n) begin
            if (ext_stall) begin
                e_pc = 0; e_ifid_we = 0;
            end else if (ex_branch_taken) begin
                e_ifid_fl = 1; e_idex_fl = 1;
            end else if (model_load_use()) begin
                e_pc = 0; e_ifid_we = 0; e_idex_fl = 1;
            end
        end
        chk("pc_we", pc_we, e_pc);
        chk("ifid_we", ifid_we, e_ifid_we);
        chk("ifid_flush", ifid_flush, e_ifid_fl);
        chk("idex_flush", idex_flush, e_idex_fl);
        chk("fwd_a", fwd_a, model_fwd(pipe[0].rs1, pipe[0].u1));
        chk("fwd_b", fwd_b, model_fwd(pipe[0].rs2, pipe[0].u2));
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, exp_stalls);
        chk("flush_cnt", flush_cnt, exp_flushes);
`endif
    endtask

    task automatic advance();
        instr_t fresh;
        bit     bubble;
        @(posedge clk);
        if (!rst_n) begin
            reset_model();
        end else if (!ext_stall) begin
            bubble = ex_branch_taken || model_load_use();
            if (ex_branch_taken) exp_flushes++;
            else if (bubble) exp_stalls++;
            fresh = '{v: id_valid, rd: int'(id_rd), rw: id_reg_write, mr: id_mem_read,
                      rs1: int'(id_rs1), rs2: int'(id_rs2), u1: id_rs1_used, u2: id_rs2_used};
            if (bubble) fresh = '{default: 0};
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = fresh;
        end
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    initial begin
        rst_n = 1'b0;
        ex_branch_taken = 1'b0;
        ext_stall = 1'b0;
        nop();
        reset_model();
        #1;
        chk("rst_fwd_a", fwd_a, 2'd0);
        chk("rst_fwd_b", fwd_b, 2'd0);
        chk("rst_pc_we", pc_we, 1'b1);
        chk("rst_ifid_we", ifid_we, 1'b1);
        cycle();
        cycle();
        rst_n = 1'b1;

        // Distance 1: add x5 then sub reading x5.
        set_id(1, 5, 1, 0, 1, 1, 2, 1); cycle();
        set_id(1, 6, 1, 0, 5, 1, 3, 1); cycle();
        nop(); settle();
        chk("d1_fwd_a", fwd_a, 2'd2);
        chk("d1_no_stall", pc_we, 1'b1);
        advance();

        // Distance 2: one NOP in between.
        set_id(1, 8, 1, 0, 1, 1, 2, 1); cycle();
        nop(); cycle();
        set_id(1, 9, 1, 0, 8, 1, 3, 1); cycle();
        nop(); settle();
        chk("d2_fwd_a", fwd_a, 2'd1);
        advance();

        // Load-use: lw x7 then add reading x7 as rs2.
        set_id(1, 7, 1, 1, 1, 1, 0, 0); cycle();
        set_id(1, 10, 1, 0, 2, 1, 7, 1); settle();
        chk("lu_pc_we", pc_we, 1'b0);
        chk("lu_ifid_we", ifid_we, 1'b0);
        chk("lu_idex_flush", idex_flush, 1'b1);
        advance();
        settle();
        chk("lu_one_cycle", pc_we, 1'b1);
        chk("lu_bubble_fwd_b", fwd_b, 2'd0);
        advance();
        nop(); settle();
        chk("lu_fwd_b", fwd_b, 2'd1);
`ifdef HAZARD_PERF_CNT_EN
        chk("lu_stall_cnt", stall_cnt, 32'd1);
`endif
        advance();

        // x0 destination never stalls or forwards.
        set_id(1, 0, 1, 1, 1, 1, 0, 0); cycle();
        set_id(1, 11, 1, 0, 0, 1, 0, 1); settle();
        chk("x0_no_stall", pc_we, 1'b1);
        chk("x0_no_flush", idex_flush, 1'b0);
        advance();
        nop(); settle();
        chk("x0_fwd_a", fwd_a, 2'd0);
        chk("x0_fwd_b", fwd_b, 2'd0);
        advance();

        // Branch coincident with a load-use condition.
        set_id(1, 12, 1, 1, 1, 1, 0, 0); cycle();
        set_id(1, 13, 1, 0, 12, 1, 0, 0);
        ex_branch_taken = 1'b1; settle();
        chk("br_ifid_flush", ifid_flush, 1'b1);
        chk("br_idex_flush", idex_flush, 1'b1);
        chk("br_pc_we", pc_we, 1'b1);
        chk("br_ifid_we", ifid_we, 1'b1);
        advance();
        ex_branch_taken = 1'b0;
        nop(); cycle();

        // ext_stall for three cycles while EX forwards from MEM.
        set_id(1, 14, 1, 0, 1, 1, 2, 1); cycle();
        set_id(1, 15, 1, 0, 14, 1, 3, 1); cycle();
        set_id(1, 16, 1, 0, 15, 1, 15, 1);
        ext_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ex_branch_taken = (k == 1);
            settle();
            chk("es_pc_we", pc_we, 1'b0);
            chk("es_ifid_flush", ifid_flush, 1'b0);
            chk("es_fwd_a", fwd_a, 2'd2);
            advance();
        end
        ext_stall = 1'b0;
        ex_branch_taken = 1'b0;
        settle();
        chk("es_resume_fwd_a", fwd_a, 2'd2);
        chk("es_resume_pc_we", pc_we, 1'b1);
        advance();
        nop(); settle();
        chk("es_after_fwd_a", fwd_a, 2'd2);
        advance();

        // Asynchronous reset mid-run.
        set_id(1, 17, 1, 0, 16, 1, 16, 1); cycle();
        rst_n = 1'b0;
        reset_model();
        #1;
        chk("arst_fwd_a", fwd_a, 2'd0);
        chk("arst_fwd_b", fwd_b, 2'd0);
        chk("arst_pc_we", pc_we, 1'b1);
        chk("arst_ex_valid", dut.tag_ex.valid, 1'b0);
        chk("arst_mem_valid", dut.tag_mem.valid, 1'b0);
        chk("arst_wb_valid", dut.tag_wb.valid, 1'b0);
        cycle();
        rst_n = 1'b1;

        // Randomized traffic on a small register set to provoke hazards.
        for (int n = 0; n < 500; n++) begin
            set_id($urandom_range(0, 99) < 85, $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1));
            ex_branch_taken = $urandom_range(0, 99) < 10;
            ext_stall       = $urandom_range(0, 99) < 10;
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                reset_model();
            end else begin
                rst_n = 1'b1;
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
